// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial word feeder and the downstream sequence
// detectors it drives.
//   state_e          : feeder FSM state encoding (IDLE / SHIFT / GAP)
//   DEF_WIDTH        : default word width in bits
//   DEF_GAP          : default idle cycles between consecutive words
//   DEF_MSB_FIRST    : default shift direction (1 = MSB first)
//   DEF_IDLE_LEVEL   : level of the serial line when no bit is being sent;
//                      the detector bench relies on the same value
//   GAP_CNT_W        : width of the inter-word gap counter (GAP up to 15)
// -----------------------------------------------------------------------------
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } state_e;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam int unsigned DEF_GAP        = 1;
    localparam bit          DEF_MSB_FIRST  = 1'b1;
    localparam bit          DEF_IDLE_LEVEL = 1'b0;
    localparam int unsigned GAP_CNT_W      = 4;

endpackage : serial_pkg

// File: rtl/piso_shift_reg.sv
// -----------------------------------------------------------------------------
// piso_shift_reg
// Parallel-in / serial-out shift register. The register holds the word with
// the bit currently on the serial line at its head (bit WIDTH-1 when
// MSB_FIRST = 1, bit 0 otherwise). A shift moves the next bit to the head.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low; clears the register
//   load_i     in   capture din_i at this edge (wins over shift_i)
//   shift_i    in   advance by one bit at this edge
//   din_i      in   parallel word
//   nxt_bit_o  out  head bit the register will hold after this edge; lets the
//                   caller register the serial output in step with the word
// -----------------------------------------------------------------------------
module piso_shift_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             nxt_bit_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = din_i;
        end else if (shift_i) begin
            if (MSB_FIRST) begin
                sr_d = {sr_q[WIDTH-2:0], 1'b0};
            end else begin
                sr_d = {1'b0, sr_q[WIDTH-1:1]};
            end
        end
    end

    // Head of the post-edge contents, i.e. the bit the caller will present next.
    assign nxt_bit_o = MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule : piso_shift_reg

// File: rtl/serial_word_feeder.sv
// -----------------------------------------------------------------------------
// serial_word_feeder
// Accepts parallel words over a valid/ready handshake and shifts them out one
// bit per clock on a registered serial line feeding a sequence detector's
// x_in. x_out only ever changes on a rising clock edge (or on reset), so a
// downstream Mealy stage sees a stable input for the whole cycle.
//
// Parameters:
//   WIDTH       bits per word (2..32)
//   MSB_FIRST   1 = bit WIDTH-1 goes out first, 0 = bit 0 first
//   GAP         idle cycles inserted between consecutive words (0..15)
//   IDLE_LEVEL  level of x_out when no data bit is being sent
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active low
//   din          in   parallel word, captured at the accept edge
//   din_valid    in   source has a word on din
//   din_ready    out  a word is accepted at the next edge if din_valid is high
//   x_out        out  serial bit (registered)
//   bit_valid    out  x_out carries a data bit this cycle (registered)
//   frame_start  out  first bit cycle of a word (registered)
//   frame_done   out  last bit cycle of a word (registered)
//   busy         out  FSM is not in IDLE
// -----------------------------------------------------------------------------
module serial_word_feeder
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter bit          MSB_FIRST  = DEF_MSB_FIRST,
    parameter int unsigned GAP        = DEF_GAP,
    parameter bit          IDLE_LEVEL = DEF_IDLE_LEVEL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_CNT_W'(GAP - 1) : '0;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;      // bits still to send after the current one
    logic [GAP_CNT_W-1:0] gap_q, gap_d;      // gap cycles still to wait after this one

    logic x_out_q, x_out_d;
    logic bit_valid_q, bit_valid_d;
    logic frame_start_q, frame_start_d;
    logic frame_done_q, frame_done_d;

    logic accept;
    logic load_en;
    logic shift_en;
    logic nxt_bit;
    logic last_bit;

    // Ready is a pure decode of state and counter so din_valid never reaches
    // an output combinationally. With GAP = 0 the last bit cycle also accepts,
    // which is what makes back-to-back words bubble-free.
    assign last_bit  = (state_q == ST_SHIFT) && (cnt_q == '0);
    assign din_ready = (state_q == ST_IDLE) || ((GAP == 0) && last_bit);
    assign busy      = (state_q != ST_IDLE);

    assign accept   = din_valid && din_ready;
    assign load_en  = accept;
    assign shift_en = (state_q == ST_SHIFT) && (cnt_q != '0);

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load_en),
        .shift_i   (shift_en),
        .din_i     (din),
        .nxt_bit_o (nxt_bit)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (GAP > 0) begin
                    state_d = ST_GAP;
                    gap_d   = GAP_LOAD;
                end else if (accept) begin
                    cnt_d = CNT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                gap_d   = '0;
            end
        endcase
    end

    // Output logic: next values of the registered serial-side outputs
    always_comb begin
        bit_valid_d   = load_en || shift_en;
        x_out_d       = bit_valid_d ? nxt_bit : IDLE_LEVEL;
        frame_start_d = load_en;
        frame_done_d  = shift_en && (cnt_q == CNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_out_q       <= IDLE_LEVEL;
            bit_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            x_out_q       <= x_out_d;
            bit_valid_q   <= bit_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign x_out       = x_out_q;
    assign bit_valid   = bit_valid_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;

endmodule : serial_word_feeder

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder. Three instances share clock and reset:
//   inst 0: MSB first, GAP = 1    inst 1: LSB first, GAP = 1    inst 2: MSB first, GAP = 0
module tb_serial_word_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din0 = '0, din1 = '0, din2 = '0;
    logic [2:0] vld = '0;

    wire [2:0] rdy_v, x_v, bv_v, fs_v, fd_v, busy_v;

    int checks = 0;
    int errors = 0;

    // Detector-side observation of instance 0's serial line
    bit         mon_en    = 1'b0;
    int         glitch_n  = 0;
    int         det_n     = 0;
    logic [7:0] det_sr    = '0;

    always #5 clk = ~clk;

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk(clk), .rst(rst), .din(din0), .din_valid(vld[0]), .din_ready(rdy_v[0]),
        .x_out(x_v[0]), .bit_valid(bv_v[0]), .frame_start(fs_v[0]),
        .frame_done(fd_v[0]), .busy(busy_v[0]));

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(1), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din1), .din_valid(vld[1]), .din_ready(rdy_v[1]),
        .x_out(x_v[1]), .bit_valid(bv_v[1]), .frame_start(fs_v[1]),
        .frame_done(fd_v[1]), .busy(busy_v[1]));

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0), .IDLE_LEVEL(1'b0)) u_b2b (
        .clk(clk), .rst(rst), .din(din2), .din_valid(vld[2]), .din_ready(rdy_v[2]),
        .x_out(x_v[2]), .bit_valid(bv_v[2]), .frame_start(fs_v[2]),
        .frame_done(fd_v[2]), .busy(busy_v[2]));

    // x_in of the detector may only move at a rising edge (times 5 mod 10)
    always @(x_v[0]) begin
        if (mon_en && (($time % 10) != 5)) glitch_n <= glitch_n + 1;
    end

    always @(posedge clk) begin
        if (mon_en && bv_v[0]) begin
            det_sr <= {det_sr[6:0], x_v[0]};
            det_n  <= det_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge of bit cycle 1; returns at the negedge after bit cycle 8.
    task automatic frame_check(input int n, input logic [7:0] w, input bit msb,
                               input bit chk_rdy, input string nm);
        for (int i = 0; i < 8; i++) begin
            logic eb;
            eb = msb ? w[7-i] : w[i];
            chk($sformatf("%s_x%0d", nm, i),  x_v[n],  eb);
            chk($sformatf("%s_bv%0d", nm, i), bv_v[n], 1'b1);
            chk($sformatf("%s_fs%0d", nm, i), fs_v[n], (i == 0));
            chk($sformatf("%s_fd%0d", nm, i), fd_v[n], (i == 7));
            if (chk_rdy) begin
                chk($sformatf("%s_rdy%0d", nm, i),  rdy_v[n],  1'b0);
                chk($sformatf("%s_busy%0d", nm, i), busy_v[n], 1'b1);
            end
            @(negedge clk);
        end
    endtask

    // Called at the negedge of the GAP cycle; checks gap then return to IDLE.
    task automatic gap_check(input int n, input string nm);
        chk({nm, "_gap_bv"},  bv_v[n],  1'b0);
        chk({nm, "_gap_x"},   x_v[n],   1'b0);
        chk({nm, "_gap_rdy"}, rdy_v[n], 1'b0);
        @(negedge clk);
        chk({nm, "_idle_rdy"},  rdy_v[n],  1'b1);
        chk({nm, "_idle_busy"}, busy_v[n], 1'b0);
    endtask

    initial begin
        // Reset state, checked while rst is asserted
        #1;
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("rst_x%0d", n),    x_v[n],    1'b0);
            chk($sformatf("rst_bv%0d", n),   bv_v[n],   1'b0);
            chk($sformatf("rst_fs%0d", n),   fs_v[n],   1'b0);
            chk($sformatf("rst_fd%0d", n),   fd_v[n],   1'b0);
            chk($sformatf("rst_busy%0d", n), busy_v[n], 1'b0);
            chk($sformatf("rst_rdy%0d", n),  rdy_v[n],  1'b1);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Basic word, MSB first: B5 -> 1,0,1,1,0,1,0,1
        din0 = 8'hB5; vld[0] = 1'b1;
        chk("basic_rdy_before", rdy_v[0], 1'b1);
        @(negedge clk);
        vld[0] = 1'b0; din0 = 8'h00;
        frame_check(0, 8'hB5, 1'b1, 1'b1, "basic");
        gap_check(0, "basic");

        // LSB first: B5 -> 1,0,1,0,1,1,0,1
        din1 = 8'hB5; vld[1] = 1'b1;
        @(negedge clk);
        vld[1] = 1'b0; din1 = 8'h00;
        frame_check(1, 8'hB5, 1'b0, 1'b1, "lsb");
        gap_check(1, "lsb");

        // Back-to-back with GAP = 0: FF then 00, source holds din_valid
        din2 = 8'hFF; vld[2] = 1'b1;
        @(negedge clk);
        din2 = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) vld[2] = 1'b0;
            chk($sformatf("b2b_x%0d", i),  x_v[2],  (i < 8));
            chk($sformatf("b2b_bv%0d", i), bv_v[2], 1'b1);
            chk($sformatf("b2b_fs%0d", i), fs_v[2], (i == 0 || i == 8));
            chk($sformatf("b2b_fd%0d", i), fd_v[2], (i == 7 || i == 15));
            chk($sformatf("b2b_rdy%0d", i), rdy_v[2], (i == 7 || i == 15));
            @(negedge clk);
        end
        chk("b2b_end_bv",   bv_v[2],   1'b0);
        chk("b2b_end_busy", busy_v[2], 1'b0);
        chk("b2b_end_rdy",  rdy_v[2],  1'b1);

        // Backpressure: 3C offered throughout SHIFT/GAP of 12
        din0 = 8'h12; vld[0] = 1'b1;
        @(negedge clk);
        din0 = 8'h3C;
        frame_check(0, 8'h12, 1'b1, 1'b1, "bp_first");
        chk("bp_gap_rdy", rdy_v[0], 1'b0);
        chk("bp_gap_bv",  bv_v[0],  1'b0);
        @(negedge clk);
        chk("bp_idle_rdy", rdy_v[0], 1'b1);
        @(negedge clk);
        vld[0] = 1'b0; din0 = 8'h00;
        frame_check(0, 8'h3C, 1'b1, 1'b1, "bp_second");
        gap_check(0, "bp_second");
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_once_bv%0d", i), bv_v[0], 1'b0);
            @(negedge clk);
        end

        // Reset mid-word: A5 -> 1,0,1,... abort after third bit
        din0 = 8'hA5; vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0; din0 = 8'h00;
        chk("mid_b1", x_v[0], 1'b1);
        @(negedge clk);
        chk("mid_b2", x_v[0], 1'b0);
        @(negedge clk);
        chk("mid_b3", x_v[0], 1'b1);
        chk("mid_b3_bv", bv_v[0], 1'b1);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_x",    x_v[0],    1'b0);
        chk("mid_rst_bv",   bv_v[0],   1'b0);
        chk("mid_rst_fd",   fd_v[0],   1'b0);
        chk("mid_rst_busy", busy_v[0], 1'b0);
        chk("mid_rst_rdy",  rdy_v[0],  1'b1);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("mid_post_bv",   bv_v[0],   1'b0);
        chk("mid_post_busy", busy_v[0], 1'b0);
        chk("mid_post_rdy",  rdy_v[0],  1'b1);
        din0 = 8'hC3; vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0; din0 = 8'h00;
        frame_check(0, 8'hC3, 1'b1, 1'b1, "mid_clean");
        gap_check(0, "mid_clean");

        // Chained detector: E0 seen as 1,1,1,0,0,0,0,0 on x_in
        mon_en = 1'b1;
        din0 = 8'hE0; vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0; din0 = 8'h00;
        frame_check(0, 8'hE0, 1'b1, 1'b0, "det");
        mon_en = 1'b0;
        chk("det_bits",    {24'h0, det_sr}, 32'h0000_00E0);
        chk("det_count",   det_n,    32'd8);
        chk("det_glitch",  glitch_n, 32'd0);
        gap_check(0, "det");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_word_feeder

// File: doc/serial_word_feeder.md
Name: serial_word_feeder

Overview:
- Upstream stage of the team's serial sequence-detector FSMs.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a registered serial line.
- The serial line drives the detector's single-bit input x_in.
- Guarantees x_out changes only on posedge clk, so a downstream Mealy stage sees stable input for a full cycle.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first.
- GAP, 1, idle cycles inserted between consecutive words; legal range 0..15.
- IDLE_LEVEL, 0, value driven on x_out whenever no bit is being sent.

Ports:
- clk  in  1  clock, rising-edge active.
- rst  in  1  reset, asynchronous, active-low.
- din  in  WIDTH  parallel word to serialise.
- din_valid  in  1  source has a word on din.
- din_ready  out  1  block can accept a word this cycle.
- x_out  out  1  serial bit; feeds downstream x_in.
- bit_valid  out  1  x_out carries a data bit this cycle.
- frame_start  out  1  high during the first bit cycle of a word.
- frame_done  out  1  high during the last bit cycle of a word.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE; shift register and bit counter cleared.
  - x_out = IDLE_LEVEL; bit_valid, frame_start, frame_done, busy = 0.
  - din_ready = 1 while in IDLE, including during reset.
- States: IDLE, SHIFT, GAP.
- Handshake:
  - A word is accepted at the posedge where din_valid && din_ready.
  - din is captured into the shift register at that edge; the source may change din afterwards.
  - din_valid without din_ready has no effect. The source holds the word; nothing is dropped or duplicated.
- IDLE:
  - din_ready = 1.
  - On accept -> SHIFT. At the same edge x_out takes the first bit and bit_valid = 1, frame_start = 1, counter = WIDTH-1.
  - Latency: the first bit is on x_out in the cycle immediately after the accept edge.
- SHIFT:
  - Each posedge presents the next bit (MSB_FIRST selects the direction) and decrements the counter.
  - bit_valid stays high for exactly WIDTH consecutive cycles.
  - frame_start is high in bit cycle 1 only; frame_done is high in bit cycle WIDTH only.
  - din_ready = 0, except during the last bit cycle when GAP = 0.
- Leaving SHIFT at the end of the last bit cycle:
  - GAP > 0: go to GAP; x_out = IDLE_LEVEL, bit_valid = 0.
  - GAP = 0 with accept: load the new word. Its first bit follows with no bubble, giving a continuous bit_valid stream, and frame_start = 1.
  - GAP = 0 without accept: return to IDLE.
- GAP:
  - Counts exactly GAP cycles with din_ready = 0, then returns to IDLE.
  - Total din_ready-low time per word = WIDTH + GAP cycles.
- Counter: width = clog2(WIDTH+1); no wrap beyond the terminal count.
- Reset mid-word: abort immediately. The partial word is discarded and not resumed after rst releases.
- All outputs are registered except din_ready and busy, which decode from the state register and counter only. There is no combinational path from din_valid to any output.

Decomposition:
- Shared package serial_pkg holds:
  - the state encoding (IDLE=2'b00, SHIFT=2'b01, GAP=2'b10);
  - the default WIDTH/GAP constants;
  - the IDLE_LEVEL default, which is reused by the downstream detector bench.
- One natural sub-module: piso_shift_reg. It is a parallel-load shift register with load/shift enables and a MSB_FIRST parameter. The FSM and counters stay in the top module.

Test Plan:
- Basic word (WIDTH=8, MSB_FIRST=1, GAP=1): din=8'hB5 accepted at edge k.
  - x_out = 1,0,1,1,0,1,0,1 in cycles k+1..k+8; bit_valid high for exactly those 8 cycles.
  - frame_start in k+1, frame_done in k+8.
  - din_ready low for 9 cycles, then high.
- LSB first (MSB_FIRST=0): din=8'hB5 -> x_out = 1,0,1,0,1,1,0,1; same timing as the basic word.
- Back-to-back (GAP=0): source holds din_valid with 8'hFF then 8'h00.
  - 16 contiguous bit_valid cycles: eight 1s then eight 0s.
  - frame_done in cycles 8 and 16; frame_start in cycles 1 and 9.
- Backpressure: din_valid asserted with 8'h3C during SHIFT of a prior word.
  - No capture during SHIFT or GAP.
  - 8'h3C is accepted on the first IDLE cycle and emitted exactly once.
- Reset mid-word: rst pulled low for 3 ns after the 3rd bit of 8'hA5.
  - x_out = IDLE_LEVEL and bit_valid = 0 immediately, without waiting for a clock.
  - din_ready = 1 after release; the next accepted word starts cleanly from bit 1.
- Chained with the downstream detector: feed 8'hE0 (MSB first). Check that the detector's x_in sees exactly the serial sequence 1,1,1,0,0,0,0,0 with one bit per clock and no glitches between edges.
